// File: rtl/wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_bridge_pkg
// Shared definitions for the Wishbone channel bridge. It holds the bridge FSM
// state encoding, the error read-back word, the channel index width and the
// bit positions of the fields in the optional status register (built with
// WB_BRIDGE_STATUS_EN).
// -----------------------------------------------------------------------------
package wb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Returned for unmapped accesses and for timed-out transfers.
   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

   // Width of the channel index. Eight channels at most.
   localparam int CH_W = 3;

   // Status register layout: {timeout_cnt, 8'h0, NCH[3:0], 3'b0, timeout}
   localparam int STAT_TO_BIT  = 0;
   localparam int STAT_NCH_LSB = 4;
   localparam int STAT_NCH_W   = 4;
   localparam int STAT_CNT_LSB = 16;
   localparam int STAT_CNT_W   = 16;

endpackage

// File: rtl/wb_addr_decode.sv
// -----------------------------------------------------------------------------
// wb_addr_decode
// Combinational address decode for the channel bridge. The channel index is
// taken from the address relative to BASE_ADR, one window of 2^WIN_BITS bytes
// per channel.
//   i_adr     : Wishbone byte address
//   o_ch      : channel index (only meaningful when o_mapped is 1)
//   o_mapped  : address lies inside one of the NCH channel windows
//   o_offset  : byte offset inside the channel window
// -----------------------------------------------------------------------------
module wb_addr_decode
   import wb_bridge_pkg::*;
#(
   parameter int          NCH      = 4,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          WIN_BITS = 12
) (
   input  logic [31:0]         i_adr,
   output logic [CH_W-1:0]     o_ch,
   output logic                o_mapped,
   output logic [WIN_BITS-1:0] o_offset
);

   logic [31:0] w_diff;
   logic [31:0] w_idx;

   assign w_diff   = i_adr - BASE_ADR;
   assign w_idx    = w_diff >> WIN_BITS;
   assign o_ch     = w_idx[CH_W-1:0];
   // The full-width index is compared so a far-away address cannot alias
   // back onto a valid channel through the truncated index.
   assign o_mapped = (i_adr >= BASE_ADR) && (w_idx < 32'(NCH));
   assign o_offset = w_diff[WIN_BITS-1:0];

endmodule

// File: rtl/wb_channel_bridge.sv
// -----------------------------------------------------------------------------
// wb_channel_bridge
// Management Wishbone slave that forwards each access to one of NCH downstream
// channels selected by address window. A transfer that no channel answers
// within TIMEOUT cycles is completed by the bridge with ERR_DATA and raises
// the sticky timeout flag plus a one-cycle interrupt pulse.
// Optional build macro WB_BRIDGE_STATUS_EN adds a status register at
// BASE_ADR + NCH*2^WIN_BITS holding the timeout counter and flag.
// Ports:
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i    : Wishbone slave request
//   wbs_ack_o, wbs_dat_o      : Wishbone slave response
//   ch_cyc_o, ch_stb_o        : one-hot downstream channel select
//   ch_we_o .. ch_dat_o       : shared downstream request fields
//   ch_dat_i, ch_ack_i        : per-channel read data / acknowledge
//   timeout_o, irq_o          : sticky timeout flag, timeout interrupt pulse
// -----------------------------------------------------------------------------
module wb_channel_bridge
   import wb_bridge_pkg::*;
#(
   parameter int          NCH      = 4,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          WIN_BITS = 12,
   parameter int          TIMEOUT  = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   output logic [NCH-1:0]      ch_cyc_o,
   output logic [NCH-1:0]      ch_stb_o,
   output logic                ch_we_o,
   output logic [3:0]          ch_sel_o,
   output logic [WIN_BITS-1:0] ch_adr_o,
   output logic [31:0]         ch_dat_o,
   input  logic [NCH*32-1:0]   ch_dat_i,
   input  logic [NCH-1:0]      ch_ack_i,
   output logic                timeout_o,
   output logic                irq_o
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t              r_state;
   logic                r_wbs_ack;
   logic [31:0]         r_wbs_dat;
   logic [NCH-1:0]      r_ch_req;
   logic                r_ch_we;
   logic [3:0]          r_ch_sel;
   logic [WIN_BITS-1:0] r_ch_adr;
   logic [31:0]         r_ch_dat;
   logic [15:0]         r_cnt;
   logic                r_timeout;
   logic                r_irq;

   logic [CH_W-1:0]     w_ch;
   logic                w_mapped;
   logic [WIN_BITS-1:0] w_offset;
   logic [NCH-1:0]      w_onehot;
   logic [NCH-1:0]      w_ack_hit;
   logic [31:0]         w_dat_term [NCH];
   logic [31:0]         w_dat_mux;
   logic                w_any_ack;

   wb_addr_decode #(
      .NCH      (NCH),
      .BASE_ADR (BASE_ADR),
      .WIN_BITS (WIN_BITS)
   ) u_decode (
      .i_adr    (wbs_adr_i),
      .o_ch     (w_ch),
      .o_mapped (w_mapped),
      .o_offset (w_offset)
   );

   // r_ch_req is the registered one-hot channel; gating acks and data with it
   // makes acks on any other channel invisible.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign w_onehot[gi]   = (w_ch == CH_W'(gi));
         assign w_ack_hit[gi]  = r_ch_req[gi] & ch_ack_i[gi];
         assign w_dat_term[gi] = r_ch_req[gi] ? ch_dat_i[32*gi +: 32] : 32'h0;
      end
   endgenerate

   always_comb begin
      w_dat_mux = 32'h0;
      for (int i = 0; i < NCH; i++) begin
         w_dat_mux = w_dat_mux | w_dat_term[i];
      end
   end

   assign w_any_ack = |w_ack_hit;

`ifdef WB_BRIDGE_STATUS_EN
   localparam logic [31:0] STATUS_ADR = BASE_ADR + (32'(NCH) << WIN_BITS);

   logic [15:0] r_to_cnt;
   logic        w_is_status;
   logic [31:0] w_status;

   assign w_is_status = (wbs_adr_i == STATUS_ADR);

   always_comb begin
      w_status = 32'h0;
      w_status[STAT_CNT_LSB +: STAT_CNT_W] = r_to_cnt;
      w_status[STAT_NCH_LSB +: STAT_NCH_W] = STAT_NCH_W'(NCH);
      w_status[STAT_TO_BIT]                = r_timeout;
   end
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= ST_IDLE;
         r_wbs_ack <= 1'b0;
         r_wbs_dat <= 32'h0;
         r_ch_req  <= '0;
         r_ch_we   <= 1'b0;
         r_ch_sel  <= 4'h0;
         r_ch_adr  <= '0;
         r_ch_dat  <= 32'h0;
         r_cnt     <= 16'h0;
         r_timeout <= 1'b0;
         r_irq     <= 1'b0;
`ifdef WB_BRIDGE_STATUS_EN
         r_to_cnt  <= 16'h0;
`endif
      end else begin
         r_wbs_ack <= 1'b0;
         r_irq     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  r_ch_we  <= wbs_we_i;
                  r_ch_sel <= wbs_sel_i;
                  r_ch_adr <= w_offset;
                  r_ch_dat <= wbs_dat_i;
                  r_cnt    <= 16'h0;
                  if (w_mapped) begin
                     r_ch_req <= w_onehot;
                     r_state  <= ST_ACCESS;
                  end
`ifdef WB_BRIDGE_STATUS_EN
                  else if (w_is_status) begin
                     r_wbs_ack <= 1'b1;
                     r_wbs_dat <= w_status;
                     if (wbs_we_i && wbs_dat_i[STAT_TO_BIT]) begin
                        r_timeout <= 1'b0;
                     end
                     r_state <= ST_RESP;
                  end
`endif
                  else begin
                     // Unmapped: answered directly, a write goes nowhere.
                     r_wbs_ack <= 1'b1;
                     r_wbs_dat <= ERR_DATA;
                     r_state   <= ST_RESP;
                  end
               end
            end

            ST_ACCESS: begin
               // Master abort wins over anything the channel does this cycle;
               // an ack wins over a timeout landing in the same cycle.
               if (!wbs_cyc_i) begin
                  r_ch_req <= '0;
                  r_state  <= ST_IDLE;
               end else if (w_any_ack) begin
                  r_ch_req  <= '0;
                  r_wbs_ack <= 1'b1;
                  r_wbs_dat <= w_dat_mux;
                  r_state   <= ST_RESP;
               end else if (r_cnt == TO_LAST) begin
                  r_ch_req  <= '0;
                  r_wbs_ack <= 1'b1;
                  r_wbs_dat <= ERR_DATA;
                  r_timeout <= 1'b1;
                  r_irq     <= 1'b1;
`ifdef WB_BRIDGE_STATUS_EN
                  if (r_to_cnt != 16'hFFFF) begin
                     r_to_cnt <= r_to_cnt + 16'h1;
                  end
`endif
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 16'h1;
               end
            end

            ST_RESP: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = r_wbs_ack;
   assign wbs_dat_o = r_wbs_dat;
   assign ch_cyc_o  = r_ch_req;
   assign ch_stb_o  = r_ch_req;
   assign ch_we_o   = r_ch_we;
   assign ch_sel_o  = r_ch_sel;
   assign ch_adr_o  = r_ch_adr;
   assign ch_dat_o  = r_ch_dat;
   assign timeout_o = r_timeout;
   assign irq_o     = r_irq;

endmodule

// File: doc/wb_channel_bridge.md
WB_CHANNEL_BRIDGE -- requirements
Module: wb_channel_bridge

Interface
REQ-001 SHALL have parameter NCH, default 4: number of downstream user channels (1..8).
REQ-002 SHALL have parameter BASE_ADR, default 32'h3000_0000: bridge base address.
REQ-003 SHALL have parameter WIN_BITS, default 12: per-channel window size of 2^WIN_BITS bytes.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before the bridge self-terminates.
REQ-005 SHALL have ports: wb_clk_i in 1 sole clock; wb_rst_i in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: wbs_cyc_i, wbs_stb_i, wbs_we_i in 1 each; wbs_sel_i in 4; wbs_adr_i, wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32: management Wishbone slave.
REQ-007 SHALL have ports: ch_cyc_o, ch_stb_o out NCH, one-hot; ch_we_o out 1; ch_sel_o out 4; ch_adr_o out WIN_BITS, window offset; ch_dat_o out 32: shared downstream request.
REQ-008 SHALL have ports: ch_dat_i in NCH*32, channel k at bits [32k+31:32k]; ch_ack_i in NCH.
REQ-009 SHALL have ports: timeout_o out 1, sticky timeout flag; irq_o out 1, one-cycle pulse per timeout.

Function
REQ-010 SHALL decode ch = (wbs_adr_i - BASE_ADR) >> WIN_BITS; mapped iff wbs_adr_i >= BASE_ADR and ch < NCH.
REQ-011 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-012 IDLE: on wbs_cyc_i & wbs_stb_i, SHALL register ch, we, sel, offset and data; mapped -> ACCESS; unmapped -> RESP with wbs_dat_o = 32'hFFFF_FFFF, and the write is discarded.
REQ-013 ACCESS: SHALL drive ch_cyc_o[ch] = ch_stb_o[ch] = 1 from registered request; all other channel bits 0.
REQ-014 ACCESS: when ch_ack_i[ch] is sampled 1, SHALL capture that channel's ch_dat_i, drop strobes, and enter RESP next cycle; acks on non-selected channels are ignored.
REQ-015 ACCESS: a cycle counter starting at 0 SHALL reach TIMEOUT-1 with no ack -> RESP with data 32'hFFFF_FFFF, timeout_o set, irq_o pulsed for one cycle.
REQ-016 An ack and the timeout occurring in the same cycle SHALL be treated as an ack: real data, no timeout.
REQ-017 RESP: SHALL assert wbs_ack_o for exactly one cycle, then return to IDLE; a new strobe is not accepted in RESP.
REQ-018 Latency: a downstream ack in the first ACCESS cycle SHALL give wbs_ack_o 2 cycles after the strobe is sampled; an unmapped access SHALL ack 1 cycle after sampling.
REQ-019 wbs_cyc_i falling during ACCESS SHALL abort: strobes drop next cycle, return to IDLE, no wbs_ack_o.
REQ-020 wbs_dat_o SHALL hold the last response until the next RESP.
REQ-021 timeout_o SHALL clear only on reset or on a write with data bit0 = 1 to the status register (REQ-025).

Reset
REQ-022 On wb_rst_i sampled high, the FSM SHALL enter IDLE, including mid-ACCESS, with no ack issued.
REQ-023 On reset, wbs_ack_o, ch_cyc_o, ch_stb_o, ch_we_o, timeout_o and irq_o SHALL be 0; ch_sel_o, ch_adr_o, ch_dat_o and wbs_dat_o SHALL be 0.

Configuration
REQ-024 Macro WB_BRIDGE_STATUS_EN SHALL gate the status register.
REQ-025 Defined: address BASE_ADR + NCH*2^WIN_BITS SHALL be an internal register, acked in 1 cycle. A read returns {timeout_cnt[15:0], 8'h0, NCH[3:0], 3'b0, timeout_o}. A write with data bit0 = 1 clears timeout_o; timeout_cnt saturates at 16'hFFFF.
REQ-026 Undefined: that address SHALL be unmapped per REQ-012; no counter hardware is present.

Structure
REQ-027 A shared package wb_bridge_pkg SHALL hold the FSM state enum, the ERR_DATA = 32'hFFFF_FFFF constant and the status-register field offsets.
REQ-028 The address decode SHALL be a sub-module wb_addr_decode (combinational: adr -> ch, mapped, offset).

Verification
REQ-029 Read channel 2, NCH=4, ch_ack_i[2] high in the first ACCESS cycle with data 32'h1234_5678 -> wbs_ack_o 2 cycles after the strobe, wbs_dat_o = 32'h1234_5678.
REQ-030 Write 32'hA5A5_0001, sel 4'b0011 to BASE_ADR+0x1004 -> ch_stb_o = 4'b0010, ch_adr_o = 12'h004, ch_dat_o and ch_sel_o match.
REQ-031 Read of BASE_ADR+0x4000 with NCH=4 and macro undefined -> ack after 1 cycle, data 32'hFFFF_FFFF, no ch_stb_o.
REQ-032 Channel 0 never acks, TIMEOUT=16 -> ack with 32'hFFFF_FFFF, timeout_o = 1, single irq_o pulse; with macro defined, status read returns count 1, and writing 1 clears timeout_o.
REQ-033 wbs_cyc_i dropped in the 2nd ACCESS cycle, or wb_rst_i asserted mid-ACCESS -> strobes low next cycle, no wbs_ack_o, the next transaction completes normally.
REQ-034 ch_ack_i[3] asserted while channel 1 is selected -> ignored; a channel 1 ack in the final timeout cycle returns real data, timeout_o stays 0.
